regxfer_ctrl: RTL and testbench

Sequencer for register-to-register transfers (TAX, TXA, TAY, TYA, TSX, TXS) between the 65C02 programmer-visible registers A, X, Y and S. It accepts one transfer command at a time over a valid/ready handshake, then drives the shared source-mux select and the one-hot CE lines of the existing `register` instances. It also updates the N and Z flags from the transferred value. It sits between the instruction decoder and the register bank.

---
 rtl/regxfer_ctrl.sv | 129 ++++++++++++
 tb/tb_regxfer_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regxfer_ctrl.sv
// regxfer_ctrl: sequences 65C02 register-to-register transfers (TAX/TXA/TAY/TYA/TSX/TXS).
// Define REGXFER_STATS_EN to build the saturating completed-write counter on XFER_COUNT.
module regxfer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_SRC,
  input  logic [1:0]       CMD_DST,
  input  logic [WIDTH-1:0] BUS,
  output logic [1:0]       SRC_SEL,
  output logic [3:0]       DST_CE,
  output logic             FLAG_N,
  output logic             FLAG_Z,
  output logic             DONE,
  output logic [15:0]      XFER_COUNT
);

  // state  | meaning
  // IDLE   | ready for a command; DONE pulses here after a transfer
  // SELECT | source mux driven, bus settling, no CE
  // WRITE  | one-hot CE to destination for one cycle; flags captured at exit
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  localparam logic [1:0] REG_S = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] src_sel_q, src_sel_d;
  logic [1:0] dst_q, dst_d;
  logic [3:0] dst_ce_q, dst_ce_d;
  logic       flag_n_q, flag_n_d;
  logic       flag_z_q, flag_z_d;
  logic       done_q, done_d;
  logic       accept;

  assign CMD_READY = (state_q == ST_IDLE);
  assign accept    = CMD_VALID && CMD_READY;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      src_sel_q <= 2'd0;
      dst_q     <= 2'd0;
      dst_ce_q  <= 4'd0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_sel_q <= src_sel_d;
      dst_q     <= dst_d;
      dst_ce_q  <= dst_ce_d;
      flag_n_q  <= flag_n_d;
      flag_z_q  <= flag_z_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SELECT;
      ST_SELECT: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_sel_d = src_sel_q;
    dst_d     = dst_q;
    dst_ce_d  = 4'd0;
    flag_n_d  = flag_n_q;
    flag_z_d  = flag_z_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_sel_d = CMD_SRC;
          dst_d     = CMD_DST;
        end
      end
      ST_SELECT: begin
        // a self-transfer is sequenced but never strobes the register
        if (src_sel_q != dst_q) dst_ce_d = 4'b0001 << dst_q;
      end
      ST_WRITE: begin
        done_d = 1'b1;
        if ((dst_ce_q != 4'd0) && (dst_q != REG_S)) begin
          flag_n_d = BUS[WIDTH-1];
          flag_z_d = (BUS == '0);
        end
      end
      default: ;
    endcase
  end

`ifdef REGXFER_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if ((state_q == ST_WRITE) && (dst_ce_q != 4'd0) && (xfer_count_q != 16'hFFFF))
      xfer_count_d = xfer_count_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) xfer_count_q <= 16'd0;
    else          xfer_count_q <= xfer_count_d;
  end

  assign XFER_COUNT = xfer_count_q;
`else
  assign XFER_COUNT = 16'd0;
`endif

  assign SRC_SEL = src_sel_q;
  assign DST_CE  = dst_ce_q;
  assign FLAG_N  = flag_n_q;
  assign FLAG_Z  = flag_z_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_regxfer_ctrl.sv
// tb_regxfer_ctrl: directed and random transfers checked cycle by cycle against a
// transaction-level reference (accept time, write cycle, done cycle).
module tb_regxfer_ctrl;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_SRC;
  logic [1:0]       CMD_DST;
  logic [WIDTH-1:0] BUS;
  logic [1:0]       SRC_SEL;
  logic [3:0]       DST_CE;
  logic             FLAG_N;
  logic             FLAG_Z;
  logic             DONE;
  logic [15:0]      XFER_COUNT;

  always #5 CLK = ~CLK;

  regxfer_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_SRC(CMD_SRC), .CMD_DST(CMD_DST), .BUS(BUS), .SRC_SEL(SRC_SEL),
    .DST_CE(DST_CE), .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z), .DONE(DONE),
    .XFER_COUNT(XFER_COUNT)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // reference: one pending transfer, accepted at the start of cycle p_e
  bit         known = 1'b0;
  bit         pend  = 1'b0;
  int         p_e   = -10;
  logic [1:0] p_src = 2'd0;
  logic [1:0] p_dst = 2'd0;
  logic [1:0] m_sel = 2'd0;
  bit         m_n   = 1'b0;
  bit         m_z   = 1'b0;
  int         m_cnt = 0;
  int         done_cyc = -10;

  int ce_pulses = 0;
  int ce_first  = -1;
  int ce_last   = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
  endtask

  task automatic check_outputs();
    logic [3:0] exp_ce;
    int         exp_cnt;
    exp_ce = 4'd0;
    if (pend && (cyc == p_e + 1) && (p_src != p_dst)) exp_ce = 4'(1 << p_dst);
`ifdef REGXFER_STATS_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("cmd_ready", 32'(CMD_READY), 32'(!pend));
    check("src_sel", 32'(SRC_SEL), 32'(m_sel));
    check("dst_ce", 32'(DST_CE), 32'(exp_ce));
    check("done", 32'(DONE), 32'(cyc == done_cyc));
    check("flag_n", 32'(FLAG_N), 32'(m_n));
    check("flag_z", 32'(FLAG_Z), 32'(m_z));
    check("xfer_count", 32'(XFER_COUNT), 32'(exp_cnt));
    if (DST_CE != 4'd0) begin
      ce_pulses++;
      if (ce_first < 0) ce_first = cyc;
      ce_last = cyc;
    end
  endtask

  // applied at the rising edge that closes cycle cyc
  task automatic model_edge();
    if (!RESET_N) begin
      known    = 1'b1;
      pend     = 1'b0;
      m_sel    = 2'd0;
      m_n      = 1'b0;
      m_z      = 1'b0;
      m_cnt    = 0;
      done_cyc = -10;
    end else if (known) begin
      if (pend && (cyc == p_e + 1)) begin
        if (p_src != p_dst) begin
          if (m_cnt < 65535) m_cnt++;
          if (p_dst != 2'd3) begin
            m_n = BUS[WIDTH-1];
            m_z = (BUS == 0);
          end
        end
        done_cyc = cyc + 1;
        pend     = 1'b0;
      end else if (!pend && CMD_VALID) begin
        pend  = 1'b1;
        p_e   = cyc + 1;
        p_src = CMD_SRC;
        p_dst = CMD_DST;
        m_sel = CMD_SRC;
      end
    end
  endtask

  task automatic drive(input bit rn, input bit v, input logic [1:0] s, input logic [1:0] d,
                       input logic [7:0] b);
    RESET_N   = rn;
    CMD_VALID = v;
    CMD_SRC   = s;
    CMD_DST   = d;
    BUS       = b;
    @(negedge CLK);
    if (known) check_outputs();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'd0, 2'd0, b);
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
    idle(2, 8'h00);
    check("rst_ready", 32'(CMD_READY), 32'd1);
    check("rst_flags", 32'({FLAG_N, FLAG_Z}), 32'd0);

    // TAX, BUS = 0x80
    drive(1'b1, 1'b1, 2'd0, 2'd1, 8'h80);
    idle(3, 8'h80);
    check("tax_flags", 32'({FLAG_N, FLAG_Z}), 32'b10);

    // TXS, BUS = 0x00: flags untouched
    ce_pulses = 0;
    drive(1'b1, 1'b1, 2'd1, 2'd3, 8'h00);
    idle(3, 8'h00);
    check("txs_ce_pulses", 32'(ce_pulses), 32'd1);
    check("txs_flags", 32'({FLAG_N, FLAG_Z}), 32'b10);

    // TYA then TAY back to back, CMD_VALID held high
    ce_pulses = 0; ce_first = -1; ce_last = -1;
    drive(1'b1, 1'b1, 2'd2, 2'd0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'd0, 2'd2, 8'h00);
    idle(4, 8'h00);
    check("b2b_ce_pulses", 32'(ce_pulses), 32'd2);
    check("b2b_ce_spacing", 32'(ce_last - ce_first), 32'd3);
    check("b2b_flag_z", 32'(FLAG_Z), 32'd1);

    // X -> X
    ce_pulses = 0;
    drive(1'b1, 1'b1, 2'd1, 2'd1, 8'h80);
    idle(3, 8'h80);
    check("self_ce_pulses", 32'(ce_pulses), 32'd0);

    // reset during SELECT
    ce_pulses = 0;
    drive(1'b1, 1'b1, 2'd0, 2'd2, 8'h33);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h33);
    idle(3, 8'h33);
    check("rst_sel_ce_pulses", 32'(ce_pulses), 32'd0);
    check("rst_sel_ready", 32'(CMD_READY), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 3))
        0:       b = 8'h00;
        1:       b = 8'h80;
        default: b = 8'($urandom);
      endcase
      drive(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), b);
    end
    idle(4, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
